// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
//
// Digit-serial adder/subtractor. Two WIDTH-bit operands are added DIGIT bits
// per clock through a DIGIT-bit ripple of full-adder slices, with the carry
// between digits held in a register. The datapath cost does not grow with
// WIDTH; an operation takes NCYC = WIDTH/DIGIT cycles plus one DONE cycle.
//
// Parameters
//   WIDTH    : operand and result width in bits (>= 1)
//   DIGIT    : bits processed per clock; must divide WIDTH exactly
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : operation request, accepted only when idle
//   sub      : 0 = a + b + cin, 1 = a - b (cin ignored); captured with start
//   a, b     : operands, captured with start
//   cin      : carry-in for add, captured with start
//   busy     : high while digits are being processed
//   done     : one-cycle pulse when sum/cout/overflow are final
//   sum      : result modulo 2^WIDTH; holds until the next accepted start
//   cout     : final carry-out (for subtract, 1 = no borrow)
//   overflow : signed two's-complement overflow of the final result
//
// Configuration
//   DIGIT_SERIAL_ADDER_OVERFLOW_EN : when defined, overflow is computed from
//   the carries into and out of the MSB on the last digit and registered with
//   sum. When undefined, no overflow logic exists and overflow is tied to 0.
// -----------------------------------------------------------------------------
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCYC  = WIDTH / DIGIT;
  // A single-digit operation still needs a 1-bit counter.
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Digit slice outputs.
  logic [DIGIT-1:0]   slice_sum;
  logic               slice_cout;
  logic [WIDTH-1:0]   slice_ext;

`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
  logic               ovf_q, ovf_d;
  logic               slice_msb_cin;
`endif

  // ---------------------------------------------------------------------------
  // DIGIT-bit ripple of full-adder slices fed by the registered carry. A local
  // running carry keeps the ripple free of self-referencing vector bits.
  // ---------------------------------------------------------------------------
  always_comb begin : digit_slice
    logic c;
    // NOTE: every combinational output gets a default before any branch or
    // loop, so no path through the block can leave it unassigned (a latch).
    c         = carry_q;
    slice_sum = '0;
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
    slice_msb_cin = carry_q;
`endif
    for (int i = 0; i < DIGIT; i++) begin
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
      // After the loop this holds the carry into the top bit of the digit,
      // which on the last digit is the carry into the operand MSB.
      slice_msb_cin = c;
`endif
      slice_sum[i] = a_q[i] ^ b_q[i] ^ c;
      c            = (a_q[i] & b_q[i]) | (a_q[i] & c) | (b_q[i] & c);
    end
    slice_cout = c;
  end

  // Place the new digit at the top of a WIDTH-wide word; it enters the sum
  // register from the MSB end so the first (LSB) digit ends up at the bottom.
  always_comb begin : slice_place
    slice_ext                    = '0;
    slice_ext[WIDTH-1 -: DIGIT]  = slice_sum;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtract is a + ~b + 1: invert B here and force the carry to 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        sum_d   = (sum_q >> DIGIT) | slice_ext;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          cout_d  = slice_cout;
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
          ovf_d   = slice_msb_cin ^ slice_cout;
`endif
          state_d = S_DONE;
        end
      end

      // A start seen here is deliberately dropped; the next request must
      // arrive while IDLE.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Operand shift registers are reset as well so that sum
  // never carries X into a later operation.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded straight from registered state, so they follow reset
  // asynchronously.
  // ---------------------------------------------------------------------------
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_adder
//
// Four instances of digit_serial_adder: WIDTH/DIGIT = 1/1, 8/1, 8/4, 8/2,
// indexed 0..3. A table of hand-computed vectors is run through the
// instances with exact cycle-by-cycle busy/done timing, followed by hand
// sequences for start-while-busy, start-in-DONE and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_digit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] start_v;
  logic [3:0] sub_v;
  logic [3:0] cin_v;
  logic [7:0] a_v [4];
  logic [7:0] b_v [4];

  wire  [3:0] busy_v;
  wire  [3:0] done_v;
  wire  [3:0] cout_v;
  wire  [3:0] ovf_v;
  wire        s_w1;
  wire  [7:0] s_d1;
  wire  [7:0] s_d4;
  wire  [7:0] s_d2;

  digit_serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_v[0]),
    .a(a_v[0][0:0]), .b(b_v[0][0:0]), .cin(cin_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sum(s_w1), .cout(cout_v[0]),
    .overflow(ovf_v[0])
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_v[1]),
    .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .sum(s_d1), .cout(cout_v[1]),
    .overflow(ovf_v[1])
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_v[2]),
    .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .sum(s_d4), .cout(cout_v[2]),
    .overflow(ovf_v[2])
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .sub(sub_v[3]),
    .a(a_v[3]), .b(b_v[3]), .cin(cin_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .sum(s_d2), .cout(cout_v[3]),
    .overflow(ovf_v[3])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sum_of(input int idx);
    case (idx)
      0:       return {7'b0, s_w1};
      1:       return s_d1;
      2:       return s_d4;
      default: return s_d2;
    endcase
  endfunction

  function automatic int ncyc_of(input int idx);
    case (idx)
      0:       return 1;
      1:       return 8;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;   // expected when overflow logic is built
  } vec_t;

  function automatic logic exp_ovf(input logic ovf);
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
    return ovf;
`else
    return 1'b0 & ovf;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation and check busy/done on every cycle through to the
  // cycle after done. Operands are scrambled right after capture.
  task automatic run_op(input vec_t v, input string tag);
    int n;
    n = ncyc_of(v.idx);
    @(negedge clk);
    a_v[v.idx]     = v.a;
    b_v[v.idx]     = v.b;
    cin_v[v.idx]   = v.cin;
    sub_v[v.idx]   = v.sub;
    start_v[v.idx] = 1'b1;
    tick();
    check({tag, " busy@k"}, busy_v[v.idx], 1'b1);
    check({tag, " done@k"}, done_v[v.idx], 1'b0);
    start_v[v.idx] = 1'b0;
    a_v[v.idx]     = ~v.a;
    b_v[v.idx]     = ~v.b;
    cin_v[v.idx]   = ~v.cin;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (c < n) begin
        check({tag, " busy mid"}, busy_v[v.idx], 1'b1);
        check({tag, " done mid"}, done_v[v.idx], 1'b0);
      end else begin
        check({tag, " done@k+n"}, done_v[v.idx], 1'b1);
        check({tag, " busy@k+n"}, busy_v[v.idx], 1'b0);
        check({tag, " sum"},      sum_of(v.idx), v.sum);
        check({tag, " cout"},     cout_v[v.idx], v.cout);
        check({tag, " ovf"},      ovf_v[v.idx], exp_ovf(v.ovf));
      end
    end
    tick();
    check({tag, " done drop"}, done_v[v.idx], 1'b0);
    check({tag, " idle"},      busy_v[v.idx], 1'b0);
  endtask

  vec_t vecs[$];

  initial begin
    // idx  a      b      cin   sub   sum    cout  ovf
    // WIDTH=1 full-adder truth table
    vecs.push_back('{0, 8'h0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0});
    vecs.push_back('{0, 8'h0, 8'h0, 1'b1, 1'b0, 8'h1, 1'b0, 1'b1});
    vecs.push_back('{0, 8'h0, 8'h1, 1'b0, 1'b0, 8'h1, 1'b0, 1'b0});
    vecs.push_back('{0, 8'h0, 8'h1, 1'b1, 1'b0, 8'h0, 1'b1, 1'b0});
    vecs.push_back('{0, 8'h1, 8'h0, 1'b0, 1'b0, 8'h1, 1'b0, 1'b0});
    vecs.push_back('{0, 8'h1, 8'h0, 1'b1, 1'b0, 8'h0, 1'b1, 1'b0});
    vecs.push_back('{0, 8'h1, 8'h1, 1'b0, 1'b0, 8'h0, 1'b1, 1'b1});
    vecs.push_back('{0, 8'h1, 8'h1, 1'b1, 1'b0, 8'h1, 1'b1, 1'b0});
    // WIDTH=8, DIGIT=1
    vecs.push_back('{1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{1, 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0});
    vecs.push_back('{1, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{1, 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0});
    // WIDTH=8, DIGIT=4
    vecs.push_back('{2, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
    vecs.push_back('{2, 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0});
    vecs.push_back('{2, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
    vecs.push_back('{2, 8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0});
    // WIDTH=8, DIGIT=2
    vecs.push_back('{3, 8'h3C, 8'h55, 1'b0, 1'b0, 8'h91, 1'b0, 1'b1});

    rst_n   = 1'b0;
    start_v = '0;
    sub_v   = '0;
    cin_v   = '0;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end

    // Reset state.
    #2;
    check("reset busy", busy_v, 4'h0);
    check("reset done", done_v, 4'h0);
    check("reset cout", cout_v, 4'h0);
    check("reset ovf",  ovf_v,  4'h0);
    check("reset sum",  {s_d2, s_d4, s_d1, 7'b0, s_w1}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // start while busy and start in DONE are both ignored (DIGIT=2, NCYC=4).
    @(negedge clk);
    a_v[3] = 8'h3C; b_v[3] = 8'h55; cin_v[3] = 1'b0; sub_v[3] = 1'b0;
    start_v[3] = 1'b1;
    tick();                                 // edge k
    start_v[3] = 1'b0;
    a_v[3] = 8'h00;
    tick();                                 // edge k+1
    start_v[3] = 1'b1;                      // seen at edge k+2, in RUN
    a_v[3] = 8'hFF; b_v[3] = 8'hFF; sub_v[3] = 1'b1; cin_v[3] = 1'b1;
    tick();                                 // edge k+2
    start_v[3] = 1'b0;
    check("busy ign busy", busy_v[3], 1'b1);
    tick();                                 // edge k+3
    check("busy ign mid", done_v[3], 1'b0);
    tick();                                 // edge k+4
    check("busy ign done", done_v[3], 1'b1);
    check("busy ign sum",  s_d2, 8'h91);
    check("busy ign cout", cout_v[3], 1'b0);
    check("busy ign ovf",  ovf_v[3], exp_ovf(1'b1));
    a_v[3] = 8'h01; b_v[3] = 8'h01; sub_v[3] = 1'b0; cin_v[3] = 1'b0;
    start_v[3] = 1'b1;                      // seen at edge k+5, in DONE
    tick();                                 // edge k+5
    start_v[3] = 1'b0;
    check("done ign busy", busy_v[3], 1'b0);
    check("done ign done", done_v[3], 1'b0);
    check("done ign sum",  s_d2, 8'h91);
    tick();                                 // edge k+6
    check("done ign idle", busy_v[3], 1'b0);

    // Reset mid-operation: immediate clear, no done afterwards.
    @(negedge clk);
    a_v[3] = 8'h3C; b_v[3] = 8'h55; cin_v[3] = 1'b0; sub_v[3] = 1'b0;
    start_v[3] = 1'b1;
    tick();                                 // edge k
    start_v[3] = 1'b0;
    tick();                                 // edge k+1
    tick();                                 // edge k+2
    rst_n = 1'b0;
    #1;
    check("rst busy", busy_v[3], 1'b0);
    check("rst done", done_v[3], 1'b0);
    check("rst sum",  s_d2, 8'h00);
    check("rst cout", cout_v[3], 1'b0);
    check("rst ovf",  ovf_v[3], 1'b0);
    tick();
    check("rst hold busy", busy_v[3], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen_done;
      seen_done = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (done_v[3] !== 1'b0 || busy_v[3] !== 1'b0) seen_done++;
      end
      check("rst no done", seen_done, 0);
    end
    run_op('{3, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0}, "post rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
